sha1_block_writer: RTL and testbench
====================================

Name: sha1_block_writer

Overview:
- Bus initiator that drives the sha1 register-interface request/response bus.
- Accepts one 512-bit message block on a valid/ready stream and writes it word-by-word into the sha1 block registers.
- Pulses process, waits for the digest, acknowledges it and forwards it on a valid/ready output.
- Sits between a message padder/scheduler and the sha1 block.

Parameters:
- DataWidth, 64, bus data width in bits; must divide 512.
- AddrWidth, 32, bus address width.
- DataBytes, DataWidth>>3, strobe width.
- ByteAlign, 1, 1: word i at BaseAddr + i*DataBytes; 0: word i at BaseAddr + i.
- BaseAddr, 0, address of block word 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- blk_valid_i  in  1  input block valid
- blk_ready_o  out  1  writer can accept a block
- blk_data_i  in  512  message block; word i = blk_data_i[i*DataWidth +: DataWidth]
- m_reqdata_o  out  DataWidth  request data
- m_reqaddr_o  out  AddrWidth  request address
- m_reqvalid_o  out  1  request valid
- m_reqwrite_o  out  1  write request, always 1 when valid
- m_reqready_i  in  1  responder ready
- m_reqstrobe_o  out  DataBytes  byte strobe, all ones when valid
- m_rspready_o  out  1  response ready
- m_rspvalid_i  in  1  response valid
- m_rspdata_i  in  DataWidth  response data, ignored
- m_rsperror_i  in  1  response error
- sha_process_o  out  1  one-cycle start pulse
- sha_digestack_o  out  1  one-cycle digest acknowledge
- sha_digest_i  in  160  digest from sha1
- sha_digestvalid_i  in  1  digest valid
- dig_valid_o  out  1  digest output valid
- dig_ready_i  in  1  downstream ready
- dig_data_o  out  160  captured digest
- err_o  out  1  one-cycle pulse: bus error, block aborted

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low. Reset drives FSM to IDLE, word counter to 0, every output to 0, and captured block and digest registers to 0.
- NumWords = 512/DataWidth (8 at default). Word counter is $clog2(NumWords) bits wide.
- FSM states:
  - IDLE: blk_ready_o=1. On blk_valid_i, capture blk_data_i, counter=0, go to REQ. blk_ready_o is 0 in every other state.
  - REQ: m_reqvalid_o=1, write=1, strobe all ones, data=word[counter], addr=BaseAddr+counter*(ByteAlign?DataBytes:1), truncated to AddrWidth. Outputs stay stable until m_reqready_i. On handshake go to RSP.
  - RSP: m_rspready_o=1. On m_rspvalid_i:
    - m_rsperror_i=1: pulse err_o, go to IDLE. No process pulse.
    - last word (counter==NumWords-1): go to START.
    - otherwise: counter+1, go to REQ.
  - START: sha_process_o=1 for exactly one cycle, go to WAIT.
  - WAIT: on sha_digestvalid_i, capture sha_digest_i into dig_data_o, pulse sha_digestack_o in the same cycle, go to OUT.
  - OUT: dig_valid_o=1, dig_data_o held stable. On dig_ready_i go to IDLE. IDLE accepts a new block the following cycle.
- Only one outstanding request; the next request is never issued before the current response is accepted.
- Minimum latency from block accept to first m_reqvalid_o: 1 cycle. Each word needs at least 2 cycles (REQ, RSP).
- A response arriving in REQ is not accepted (m_rspready_o=0).
- sha_digestvalid_i outside WAIT is ignored.
- Reset mid-transaction returns to IDLE immediately; no partial pulses follow.

Decomposition:
- Package sha_pkg holds BlockWidth=512, DigestWidth=160 and the FSM state enum (IDLE, REQ, RSP, START, WAIT, OUT).
- No sub-module; word select and address generation are inline logic.

Test Plan:
- Default params, responder always ready, block words 0x0..0x7 -> 8 writes to addresses 0x00,0x08,...,0x38 with data 0..7 in order, strobe 0xFF, one sha_process_o pulse after the 8th response.
- m_reqready_i held low 5 cycles on word 3 -> addr 0x18 and data 3 held stable throughout; no later word issued early.
- m_rsperror_i=1 on word 2's response -> one err_o pulse, no sha_process_o, blk_ready_o=1 next cycle, no further requests.
- sha_digestvalid_i with digest 0xA9993E364706816ABA3E25717850C26C9CD0D89D -> one sha_digestack_o pulse, dig_data_o equals that value, dig_valid_o held while dig_ready_i low for 3 cycles, IDLE after the handshake.
- ByteAlign=0, BaseAddr=0x100 -> addresses 0x100..0x107.
- rst_ni asserted while in RSP on word 4 -> all outputs 0 asynchronously; after release, a new block restarts from word 0.

Source files
------------

// File: rtl/sha1_block_writer_pkg.sv
// Shared widths and FSM state encoding for the sha1 block writer.
package sha_pkg;

    localparam int unsigned BlockWidth  = 512;
    localparam int unsigned DigestWidth = 160;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RSP,
        START,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/sha1_block_writer.sv
// Bus initiator: writes one 512-bit block into the sha1 registers word by word,
// starts the hash, then forwards the returned digest on a valid/ready port.
module sha1_block_writer
    import sha_pkg::*;
#(
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataBytes = DataWidth >> 3,
    parameter int unsigned          ByteAlign = 1,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [BlockWidth-1:0]  blk_data_i,
    output logic [DataWidth-1:0]   m_reqdata_o,
    output logic [AddrWidth-1:0]   m_reqaddr_o,
    output logic                   m_reqvalid_o,
    output logic                   m_reqwrite_o,
    input  logic                   m_reqready_i,
    output logic [DataBytes-1:0]   m_reqstrobe_o,
    output logic                   m_rspready_o,
    input  logic                   m_rspvalid_i,
    input  logic [DataWidth-1:0]   m_rspdata_i,
    input  logic                   m_rsperror_i,
    output logic                   sha_process_o,
    output logic                   sha_digestack_o,
    input  logic [DigestWidth-1:0] sha_digest_i,
    input  logic                   sha_digestvalid_i,
    output logic                   dig_valid_o,
    input  logic                   dig_ready_i,
    output logic [DigestWidth-1:0] dig_data_o,
    output logic                   err_o
);

    localparam int unsigned NumWords = BlockWidth / DataWidth;
    localparam int unsigned CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumWords - 1);
    localparam logic [AddrWidth-1:0] Stride =
        (ByteAlign != 0) ? AddrWidth'(DataBytes) : AddrWidth'(1);

    state_t                  state;
    logic [CntW-1:0]         cnt;
    logic [BlockWidth-1:0]   blk_q;
    logic [CntW-1:0]         next_cnt;
    logic [DataWidth-1:0]    next_word;
    logic [AddrWidth-1:0]    next_addr;
    logic                    unused_rspdata;

    assign unused_rspdata = ^m_rspdata_i;

    always_comb begin
        next_cnt  = cnt + CntW'(1);
        next_word = blk_q[int'(next_cnt) * DataWidth +: DataWidth];
        next_addr = BaseAddr + AddrWidth'(next_cnt) * Stride;
    end

    // Acknowledge must coincide with the digest-valid cycle, so it is decoded
    // from the registered state rather than registered itself.
    assign sha_digestack_o = (state == WAIT) && sha_digestvalid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            cnt           <= '0;
            blk_q         <= '0;
            blk_ready_o   <= 1'b0;
            m_reqdata_o   <= '0;
            m_reqaddr_o   <= '0;
            m_reqvalid_o  <= 1'b0;
            m_reqwrite_o  <= 1'b0;
            m_reqstrobe_o <= '0;
            m_rspready_o  <= 1'b0;
            sha_process_o <= 1'b0;
            dig_valid_o   <= 1'b0;
            dig_data_o    <= '0;
            err_o         <= 1'b0;
        end else begin
            err_o         <= 1'b0;
            sha_process_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (blk_ready_o && blk_valid_i) begin
                        blk_q         <= blk_data_i;
                        cnt           <= '0;
                        blk_ready_o   <= 1'b0;
                        m_reqdata_o   <= blk_data_i[DataWidth-1:0];
                        m_reqaddr_o   <= BaseAddr;
                        m_reqvalid_o  <= 1'b1;
                        m_reqwrite_o  <= 1'b1;
                        m_reqstrobe_o <= '1;
                        state         <= REQ;
                    end else begin
                        blk_ready_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (m_reqready_i) begin
                        m_reqvalid_o  <= 1'b0;
                        m_reqwrite_o  <= 1'b0;
                        m_reqstrobe_o <= '0;
                        m_rspready_o  <= 1'b1;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    if (m_rspvalid_i) begin
                        m_rspready_o <= 1'b0;
                        if (m_rsperror_i) begin
                            err_o       <= 1'b1;
                            blk_ready_o <= 1'b1;
                            state       <= IDLE;
                        end else if (cnt == LastCnt) begin
                            sha_process_o <= 1'b1;
                            state         <= START;
                        end else begin
                            cnt           <= next_cnt;
                            m_reqdata_o   <= next_word;
                            m_reqaddr_o   <= next_addr;
                            m_reqvalid_o  <= 1'b1;
                            m_reqwrite_o  <= 1'b1;
                            m_reqstrobe_o <= '1;
                            state         <= REQ;
                        end
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    if (sha_digestvalid_i) begin
                        dig_data_o  <= sha_digest_i;
                        dig_valid_o <= 1'b1;
                        state       <= OUT;
                    end
                end
                OUT: begin
                    if (dig_ready_i) begin
                        dig_valid_o <= 1'b0;
                        blk_ready_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_block_writer.sv
// Directed bench for sha1_block_writer: a default instance and a word-addressed
// instance at 0x100 share all inputs and are checked side by side.
module tb_sha1_block_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         reqready, rspvalid, rsperror;
    logic [63:0]  rspdata;
    logic [159:0] digest;
    logic         digestvalid, dig_ready;

    logic         blk_ready0, reqvalid0, reqwrite0, rspready0, process0, ack0, digvalid0, err0;
    logic [63:0]  reqdata0;
    logic [31:0]  reqaddr0;
    logic [7:0]   strobe0;
    logic [159:0] digdata0;

    logic         blk_ready1, reqvalid1, reqwrite1, rspready1, process1, ack1, digvalid1, err1;
    logic [63:0]  reqdata1;
    logic [31:0]  reqaddr1;
    logic [7:0]   strobe1;
    logic [159:0] digdata1;

    int checks = 0;
    int failures = 0;

    localparam logic [159:0] Digest = 160'hA9993E364706816ABA3E25717850C26C9CD0D89D;

    always #5 clk = ~clk;

    sha1_block_writer dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready0), .blk_data_i(blk_data),
        .m_reqdata_o(reqdata0), .m_reqaddr_o(reqaddr0), .m_reqvalid_o(reqvalid0),
        .m_reqwrite_o(reqwrite0), .m_reqready_i(reqready), .m_reqstrobe_o(strobe0),
        .m_rspready_o(rspready0), .m_rspvalid_i(rspvalid), .m_rspdata_i(rspdata),
        .m_rsperror_i(rsperror), .sha_process_o(process0), .sha_digestack_o(ack0),
        .sha_digest_i(digest), .sha_digestvalid_i(digestvalid),
        .dig_valid_o(digvalid0), .dig_ready_i(dig_ready), .dig_data_o(digdata0),
        .err_o(err0)
    );

    sha1_block_writer #(.ByteAlign(0), .BaseAddr(32'h100)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .blk_valid_i(blk_valid), .blk_ready_o(blk_ready1), .blk_data_i(blk_data),
        .m_reqdata_o(reqdata1), .m_reqaddr_o(reqaddr1), .m_reqvalid_o(reqvalid1),
        .m_reqwrite_o(reqwrite1), .m_reqready_i(reqready), .m_reqstrobe_o(strobe1),
        .m_rspready_o(rspready1), .m_rspvalid_i(rspvalid), .m_rspdata_i(rspdata),
        .m_rsperror_i(rsperror), .sha_process_o(process1), .sha_digestack_o(ack1),
        .sha_digest_i(digest), .sha_digestvalid_i(digestvalid),
        .dig_valid_o(digvalid1), .dig_ready_i(dig_ready), .dig_data_o(digdata1),
        .err_o(err1)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [63:0] base);
        for (int i = 0; i < 8; i++) blk_data[i*64 +: 64] = base + 64'(i);
    endtask

    // Wait for word k's request, stall it, check it, and complete the handshake.
    task automatic do_req(input int k, input logic [63:0] d, input int stall);
        int n = 0;
        while (!reqvalid0 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {159'd0, reqvalid0}, 160'd1);
        chk("req_addr", {128'd0, reqaddr0}, 160'(k * 8));
        chk("req_addr_word", {128'd0, reqaddr1}, 160'(32'h100 + k));
        chk("req_data", {96'd0, reqdata0}, {96'd0, d});
        chk("req_strobe_write", {151'd0, strobe0, reqwrite0}, {151'd0, 8'hFF, 1'b1});
        chk("rspready_in_req", {159'd0, rspready0}, 160'd0);
        for (int s = 0; s < stall; s++) begin
            step();
            chk("stall_valid", {159'd0, reqvalid0}, 160'd1);
            chk("stall_addr", {128'd0, reqaddr0}, 160'(k * 8));
            chk("stall_data", {96'd0, reqdata0}, {96'd0, d});
        end
        reqready = 1'b1;
        step();
        reqready = 1'b0;
        chk("rsp_wait_noreq", {158'd0, reqvalid0, rspready0}, 160'd1);
    endtask

    task automatic do_rsp(input logic err);
        rspvalid = 1'b1;
        rsperror = err;
        step();
        rspvalid = 1'b0;
        rsperror = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0;
        reqready = 1'b0; rspvalid = 1'b0; rsperror = 1'b0; rspdata = 64'hDEAD;
        digest = '0; digestvalid = 1'b0; dig_ready = 1'b0;
        repeat (2) step();
        chk("reset_ctl", {151'd0, blk_ready0, reqvalid0, reqwrite0, rspready0, process0,
                          ack0, digvalid0, err0}, 160'd0);
        chk("reset_bus", {88'd0, reqaddr0, strobe0, 32'd0}, 160'd0);
        chk("reset_dig", digdata0, 160'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", {159'd0, blk_ready0}, 160'd1);

        // sha_digestvalid_i outside WAIT must be ignored
        digestvalid = 1'b1; digest = Digest;
        #1;
        chk("ack_ignored_idle", {159'd0, ack0}, 160'd0);
        step();
        digestvalid = 1'b0;
        chk("digvalid_ignored_idle", {159'd0, digvalid0}, 160'd0);

        // Full block, stall on word 3
        load_block(64'd0);
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        chk("accept_ready_low", {159'd0, blk_ready0}, 160'd0);
        for (int k = 0; k < 8; k++) begin
            do_req(k, 64'(k), (k == 3) ? 5 : 0);
            chk("no_process_early", {159'd0, process0}, 160'd0);
            do_rsp(1'b0);
        end
        chk("process_pulse", {158'd0, process0, process1}, 160'd3);
        step();
        chk("process_one_cycle", {159'd0, process0}, 160'd0);
        step();
        chk("ack_idle_wait", {159'd0, ack0}, 160'd0);
        digestvalid = 1'b1; digest = Digest;
        #1;
        chk("ack_pulse", {159'd0, ack0}, 160'd1);
        step();
        digestvalid = 1'b0; digest = '0;
        chk("ack_one_cycle", {159'd0, ack0}, 160'd0);
        for (int c = 0; c < 3; c++) begin
            chk("dig_valid_hold", {159'd0, digvalid0}, 160'd1);
            chk("dig_data_hold", digdata0, Digest);
            step();
        end
        dig_ready = 1'b1;
        step();
        dig_ready = 1'b0;
        chk("dig_done", {158'd0, digvalid0, blk_ready0}, 160'd1);

        // Error on word 2
        load_block(64'h10);
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        do_req(0, 64'h10, 0); do_rsp(1'b0);
        do_req(1, 64'h11, 0); do_rsp(1'b0);
        do_req(2, 64'h12, 0); do_rsp(1'b1);
        chk("err_pulse", {157'd0, err0, blk_ready0, process0}, 160'd6);
        step();
        chk("err_one_cycle", {159'd0, err0}, 160'd0);
        for (int c = 0; c < 3; c++) begin
            chk("err_no_req", {158'd0, reqvalid0, process0}, 160'd0);
            step();
        end

        // Reset while in RSP on word 4
        load_block(64'h20);
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_req(k, 64'h20 + 64'(k), 0);
            do_rsp(1'b0);
        end
        do_req(4, 64'h24, 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", {155'd0, rspready0, reqvalid0, blk_ready0, process0, err0}, 160'd0);
        chk("async_reset_addr", {128'd0, reqaddr0}, 160'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_reset_ready", {159'd0, blk_ready0}, 160'd1);
        load_block(64'h30);
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            do_req(k, 64'h30 + 64'(k), 0);
            do_rsp(1'b0);
        end
        chk("restart_process", {159'd0, process0}, 160'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
